// File: rtl/div_sqrt_arb_mvp.sv
// rtl/div_sqrt_arb_mvp.sv - round-robin arbiter/sequencer sharing one div/sqrt unit
// Grants one requester at a time, muxes its operands and routes done/kill/timeout back to the owner.
module div_sqrt_arb_mvp #(
  parameter int NUM_REQ = 2,
  parameter int TIMEOUT = 64,
  localparam int IDW = $clog2(NUM_REQ)
) (
  input  logic                     Clk_CI,
  input  logic                     Rst_RBI,
  input  logic [NUM_REQ-1:0]       Req_SI,
  input  logic [NUM_REQ-1:0]       Op_sqrt_SI,
  input  logic [NUM_REQ-1:0]       Kill_SI,
  input  logic [NUM_REQ-1:0][1:0]  Format_sel_SI,
  input  logic [NUM_REQ-1:0][5:0]  Precision_ctl_SI,
  input  logic [NUM_REQ-1:0][63:0] Operand_a_DI,
  input  logic [NUM_REQ-1:0][63:0] Operand_b_DI,
  input  logic                     Unit_ready_SI,
  input  logic                     Unit_done_SI,
  output logic [NUM_REQ-1:0]       Gnt_SO,
  output logic                     Div_start_SO,
  output logic                     Sqrt_start_SO,
  output logic                     Kill_SO,
  output logic [1:0]               Format_sel_SO,
  output logic [5:0]               Precision_ctl_SO,
  output logic [63:0]              Operand_a_DO,
  output logic [63:0]              Operand_b_DO,
  output logic [NUM_REQ-1:0]       Done_SO,
  output logic [IDW-1:0]           Owner_SO,
  output logic                     Busy_SO,
  output logic                     Timeout_SO
);

  localparam bit       WD_EN   = (TIMEOUT != 0);
  localparam logic [7:0] WD_LAST = WD_EN ? 8'(TIMEOUT - 1) : 8'd0;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t           state;
  logic [IDW-1:0]   ptr;
  logic [IDW-1:0]   owner;
  logic [7:0]       cnt;

  logic [NUM_REQ-1:0]   eligible;
  logic [2*NUM_REQ-1:0] rot;
  logic                 found;
  logic [IDW-1:0]       win;
  logic                 grant;
  logic [IDW-1:0]       sel;
  logic                 kill_own;
  logic                 wd_fire;
  logic                 done_fire;
  int                   sum;

  // Rotate the eligible vector so bit 0 is the RR pointer, then take the first set bit.
  always_comb begin
    eligible = Req_SI & ~Kill_SI;
    rot      = {eligible, eligible} >> ptr;
    found    = 1'b0;
    win      = '0;
    sum      = 0;
    for (int j = 0; j < NUM_REQ; j++) begin
      if (!found && rot[j]) begin
        found = 1'b1;
        sum   = int'(ptr) + j;
        if (sum >= NUM_REQ) sum = sum - NUM_REQ;
        win   = IDW'(sum);
      end
    end
  end

  // Gated by reset so no grant pulse escapes while reset is held.
  assign grant     = Rst_RBI && (state == IDLE) && Unit_ready_SI && found;
  assign kill_own  = (state == BUSY) && Kill_SI[owner];
  assign wd_fire   = WD_EN && (state == BUSY) && !kill_own && (cnt == WD_LAST);
  assign done_fire = (state == BUSY) && !kill_own && !wd_fire && Unit_done_SI;

  assign sel = grant ? win : ((state == BUSY) ? owner : '0);

  assign Gnt_SO           = grant ? (NUM_REQ'(1) << win) : '0;
  assign Div_start_SO     = grant && !Op_sqrt_SI[win];
  assign Sqrt_start_SO    = grant && Op_sqrt_SI[win];
  assign Kill_SO          = kill_own || wd_fire;
  assign Timeout_SO       = wd_fire;
  assign Done_SO          = (wd_fire || done_fire) ? (NUM_REQ'(1) << owner) : '0;
  assign Busy_SO          = (state == BUSY);
  assign Owner_SO         = owner;
  assign Format_sel_SO    = Format_sel_SI[sel];
  assign Precision_ctl_SO = Precision_ctl_SI[sel];
  assign Operand_a_DO     = Operand_a_DI[sel];
  assign Operand_b_DO     = Operand_b_DI[sel];

  always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
    if (!Rst_RBI) begin
      state <= IDLE;
      ptr   <= '0;
      owner <= '0;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant) begin
            state <= BUSY;
            owner <= win;
            ptr   <= (win == IDW'(NUM_REQ - 1)) ? '0 : win + IDW'(1);
            cnt   <= '0;
          end
        end
        BUSY: begin
          if (cnt != 8'hFF) cnt <= cnt + 8'd1;
          if (kill_own || wd_fire || done_fire) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_div_sqrt_arb_mvp.sv
// tb/tb_div_sqrt_arb_mvp.sv - self-checking bench for div_sqrt_arb_mvp
// Directed scenarios plus random traffic, all checked against a cycle-level reference model.
module tb_div_sqrt_arb_mvp;
  localparam int N  = 2;
  localparam int TO = 64;

  logic clk = 1'b0;
  logic rst_n;
  logic [N-1:0]       req, op, kill;
  logic [N-1:0][1:0]  fmt;
  logic [N-1:0][5:0]  prec;
  logic [N-1:0][63:0] opa, opb;
  logic               ready, done_in;

  logic [N-1:0] gnt, done_o;
  logic         div_start, sqrt_start, kill_o, busy_o, timeout_o;
  logic [1:0]   fmt_o;
  logic [5:0]   prec_o;
  logic [63:0]  opa_o, opb_o;
  logic [0:0]   owner_o;

  logic [N-1:0] nt_gnt, nt_done;
  logic         nt_div, nt_sqrt, nt_kill, nt_busy, nt_to;
  logic [1:0]   nt_fmt;
  logic [5:0]   nt_prec;
  logic [63:0]  nt_opa, nt_opb;
  logic [0:0]   nt_owner;

  div_sqrt_arb_mvp #(.NUM_REQ(N), .TIMEOUT(TO)) dut (
    .Clk_CI(clk), .Rst_RBI(rst_n), .Req_SI(req), .Op_sqrt_SI(op), .Kill_SI(kill),
    .Format_sel_SI(fmt), .Precision_ctl_SI(prec), .Operand_a_DI(opa), .Operand_b_DI(opb),
    .Unit_ready_SI(ready), .Unit_done_SI(done_in), .Gnt_SO(gnt), .Div_start_SO(div_start),
    .Sqrt_start_SO(sqrt_start), .Kill_SO(kill_o), .Format_sel_SO(fmt_o),
    .Precision_ctl_SO(prec_o), .Operand_a_DO(opa_o), .Operand_b_DO(opb_o), .Done_SO(done_o),
    .Owner_SO(owner_o), .Busy_SO(busy_o), .Timeout_SO(timeout_o)
  );

  div_sqrt_arb_mvp #(.NUM_REQ(N), .TIMEOUT(0)) dut_nt (
    .Clk_CI(clk), .Rst_RBI(rst_n), .Req_SI(req), .Op_sqrt_SI(op), .Kill_SI(kill),
    .Format_sel_SI(fmt), .Precision_ctl_SI(prec), .Operand_a_DI(opa), .Operand_b_DI(opb),
    .Unit_ready_SI(ready), .Unit_done_SI(done_in), .Gnt_SO(nt_gnt), .Div_start_SO(nt_div),
    .Sqrt_start_SO(nt_sqrt), .Kill_SO(nt_kill), .Format_sel_SO(nt_fmt),
    .Precision_ctl_SO(nt_prec), .Operand_a_DO(nt_opa), .Operand_b_DO(nt_opb), .Done_SO(nt_done),
    .Owner_SO(nt_owner), .Busy_SO(nt_busy), .Timeout_SO(nt_to)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  bit m_busy;
  int m_owner, m_ptr, m_cnt;
  int busy_seen, to_seen;
  logic [N-1:0] last_gnt;
  logic         last_sqrt;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // One clock cycle: predict outputs from the current inputs, compare mid-cycle, then advance the model.
  task automatic step();
    logic [N-1:0] e_gnt, e_done;
    logic e_div, e_sqrt, e_kill, e_to, e_busy;
    logic [0:0] sel, e_owner, ib;
    bit g;
    int w, i;
    bit n_busy;
    int n_owner, n_ptr, n_cnt;
    e_gnt = '0; e_done = '0; e_div = 0; e_sqrt = 0; e_kill = 0; e_to = 0;
    sel = '0; g = 0; w = 0;
    n_busy = m_busy; n_owner = m_owner; n_ptr = m_ptr; n_cnt = m_cnt;
    e_busy  = rst_n ? m_busy : 1'b0;
    e_owner = rst_n ? 1'(m_owner) : 1'b0;
    if (!rst_n) begin
      n_busy = 0; n_owner = 0; n_ptr = 0; n_cnt = 0;
    end else if (!m_busy) begin
      if (ready) begin
        for (int k = 0; k < N; k++) begin
          i  = (m_ptr + k) % N;
          ib = 1'(i);
          if (!g && req[ib] && !kill[ib]) begin
            g = 1; w = i;
          end
        end
      end
      if (g) begin
        sel    = 1'(w);
        e_gnt  = N'(1) << w;
        e_div  = !op[sel];
        e_sqrt = op[sel];
        n_busy = 1; n_owner = w; n_ptr = (w + 1) % N; n_cnt = 0;
      end
    end else begin
      sel = 1'(m_owner);
      if (kill[sel]) begin
        e_kill = 1; n_busy = 0;
      end else if (TO != 0 && m_cnt == TO - 1) begin
        e_kill = 1; e_to = 1; e_done = N'(1) << m_owner; n_busy = 0;
      end else if (done_in) begin
        e_done = N'(1) << m_owner; n_busy = 0;
      end
      n_cnt = (m_cnt < 255) ? m_cnt + 1 : 255;
    end
    #3;
    check("gnt", 64'(gnt), 64'(e_gnt));
    check("div_start", 64'(div_start), 64'(e_div));
    check("sqrt_start", 64'(sqrt_start), 64'(e_sqrt));
    check("kill_out", 64'(kill_o), 64'(e_kill));
    check("timeout", 64'(timeout_o), 64'(e_to));
    check("done", 64'(done_o), 64'(e_done));
    check("busy", 64'(busy_o), 64'(e_busy));
    check("owner", 64'(owner_o), 64'(e_owner));
    check("fmt_mux", 64'(fmt_o), 64'(fmt[sel]));
    check("prec_mux", 64'(prec_o), 64'(prec[sel]));
    check("opa_mux", opa_o, opa[sel]);
    check("opb_mux", opb_o, opb[sel]);
    if (busy_o === 1'b1) busy_seen++;
    if (timeout_o === 1'b1) to_seen++;
    last_gnt  = gnt;
    last_sqrt = sqrt_start;
    @(posedge clk);
    #1;
    m_busy = n_busy; m_owner = n_owner; m_ptr = n_ptr; m_cnt = n_cnt;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; req = '0; op = '0; kill = '0; ready = 1'b1; done_in = 1'b0;
    for (int r = 0; r < N; r++) begin
      fmt[r]  = 2'(r + 1);
      prec[r] = 6'(r + 10);
      opa[r]  = {$urandom, $urandom};
      opb[r]  = {$urandom, $urandom};
    end
    m_busy = 0; m_owner = 0; m_ptr = 0; m_cnt = 0;
    @(posedge clk);
    #1;
    req = 2'b11;
    step();
    step();
    rst_n = 1'b1;
    req = '0;

    // single div, done 20 cycles after start
    req = 2'b01; op = 2'b00;
    step();
    check("single_gnt", 64'(last_gnt), 64'(2'b01));
    req = '0;
    busy_seen = 0;
    for (int c = 0; c < 19; c++) step();
    done_in = 1'b1;
    step();
    done_in = 1'b0;
    step();
    check("single_busy_len", 64'(busy_seen), 64'd20);

    // round robin with both requesting
    do_reset();
    req = 2'b11; op = 2'b10;
    for (int j = 0; j < 4; j++) begin
      step();
      check("rr_order", 64'(last_gnt), (j % 2 == 0) ? 64'd1 : 64'd2);
      check("rr_sqrt", 64'(last_sqrt), 64'(j % 2));
      for (int c = 0; c < 4; c++) step();
      done_in = 1'b1;
      step();
      done_in = 1'b0;
    end
    req = '0;
    step();

    // operand mux held while the other requester toggles
    do_reset();
    req = 2'b10; opa[1] = 64'h4000000000000000; fmt[1] = 2'd0;
    step();
    req = '0;
    for (int c = 0; c < 8; c++) begin
      opa[0] = {$urandom, $urandom};
      fmt[0] = 2'($urandom);
      step();
      check("opmux_hold", opa_o, 64'h4000000000000000);
    end
    done_in = 1'b1;
    step();
    done_in = 1'b0;

    // kill from non-owner ignored, owner kill beats done
    req = 2'b10;
    step();
    req = '0;
    kill = 2'b01;
    step();
    kill = 2'b10; done_in = 1'b1;
    step();
    kill = '0; done_in = 1'b0;
    step();

    // watchdog
    do_reset();
    req = 2'b01;
    step();
    req = '0;
    to_seen = 0;
    for (int c = 0; c < 70; c++) step();
    check("wd_fired_once", 64'(to_seen), 64'd1);
    check("wd_disabled_busy", 64'(nt_busy), 64'd1);
    done_in = 1'b1;
    step();
    done_in = 1'b0;
    check("wd_disabled_release", 64'(nt_busy), 64'd0);

    // unit not ready, then reset mid-busy
    ready = 1'b0; req = 2'b11;
    for (int c = 0; c < 3; c++) step();
    ready = 1'b1;
    step();
    req = '0;
    for (int c = 0; c < 3; c++) step();
    rst_n = 1'b0;
    step();
    check("rst_busy", 64'(busy_o), 64'd0);
    rst_n = 1'b1;
    req = 2'b10;
    step();
    check("post_rst_gnt", 64'(last_gnt), 64'(2'b10));
    req = '0;
    done_in = 1'b1;
    step();
    done_in = 1'b0;

    // random traffic
    for (int c = 0; c < 800; c++) begin
      req     = 2'($urandom_range(0, 3));
      op      = 2'($urandom_range(0, 3));
      kill    = ($urandom_range(0, 15) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      ready   = ($urandom_range(0, 3) != 0);
      done_in = ($urandom_range(0, 5) == 0);
      if ($urandom_range(0, 3) == 0) begin
        for (int r = 0; r < N; r++) begin
          fmt[r]  = 2'($urandom);
          prec[r] = 6'($urandom);
          opa[r]  = {$urandom, $urandom};
          opb[r]  = {$urandom, $urandom};
        end
      end
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
